rhs2116_frame_deframer: RTL and testbench

//  Parametrised deframer behind the link CDR. Consumes recovered bits (bit_in/bit_valid), hunts the

---
 rtl/rhs2116_frame_deframer.sv | 183 ++++++++++++++++++
 tb/tb_rhs2116_frame_deframer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rhs2116_frame_deframer.sv
// rtl/rhs2116_frame_deframer.sv - sync hunt, frame assembly, CRC-8 check and lock tracking for the recovered bit stream
module rhs2116_frame_deframer #(
  parameter logic [7:0] SYNC_WORD   = 8'hAA,
  parameter int         CNT_W       = 8,
  parameter int         DATA_W      = 32,
  parameter logic [7:0] CRC_POLY    = 8'h07,
  parameter int         LOCK_FRAMES = 2,
  parameter int         LOSS_ERRORS = 3,
  parameter int         MAX_GAP     = 64
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              data_valid,
  output logic              locked,
  output logic              frame_error,
  output logic              seq_error,
  output logic              sync_lost
);

  localparam int BODY_W       = CNT_W + DATA_W;
  localparam int COLLECT_BITS = BODY_W + 8;
  localparam int BW           = $clog2(COLLECT_BITS);
  localparam int GW           = $clog2(LOCK_FRAMES + 1);
  localparam int EW           = $clog2(LOSS_ERRORS + 1);
  localparam int PW           = $clog2(MAX_GAP + 1);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_FRAMES);
  localparam logic [EW-1:0] LOSS_N = EW'(LOSS_ERRORS);
  localparam logic [PW-1:0] GAP_N  = PW'(MAX_GAP);

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? CRC_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] crc_of_byte(input logic [7:0] v);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 7; i >= 0; i--) c = crc_step(c, v[i]);
    return c;
  endfunction

  // The sync byte is only recognised after it is complete, so its CRC is seeded as a constant.
  localparam logic [7:0] SYNC_CRC = crc_of_byte(SYNC_WORD);

  typedef enum logic [1:0] {HUNT, COLLECT, SEEK} state_t;

  state_t                  state;
  logic [6:0]              win;
  logic [2:0]              fill;
  logic [BW-1:0]           bit_cnt;
  logic [7:0]              crc;
  logic [COLLECT_BITS-2:0] shreg;
  logic [GW-1:0]           good_cnt;
  logic [EW-1:0]           err_cnt;
  logic [PW-1:0]           gap_cnt;
  logic                    prev_valid;
  logic [CNT_W-1:0]        prev_cnt;

  logic [7:0]              win_next;
  logic                    sync_hit;
  logic                    frame_last;
  logic [COLLECT_BITS-1:0] full;
  logic [CNT_W-1:0]        rx_cnt;
  logic [DATA_W-1:0]       rx_data;
  logic                    crc_ok;
  logic [GW-1:0]           good_inc;
  logic [EW-1:0]           err_inc;
  logic [PW-1:0]           gap_inc;
  logic                    gap_hit;
  logic                    bad_event;

  // fill guards against matching on bits left over from the previous frame.
  assign win_next   = {win, bit_in};
  assign sync_hit   = (fill == 3'd7) && (win_next == SYNC_WORD);
  assign frame_last = (bit_cnt == BW'(COLLECT_BITS - 1));
  assign full       = {shreg, bit_in};
  assign rx_cnt     = full[COLLECT_BITS-1 -: CNT_W];
  assign rx_data    = full[DATA_W+7 -: DATA_W];
  assign crc_ok     = (full[7:0] == crc);
  assign good_inc   = (good_cnt == LOCK_N) ? good_cnt : good_cnt + GW'(1);
  assign err_inc    = err_cnt + EW'(1);
  assign gap_inc    = gap_cnt + PW'(1);
  assign gap_hit    = (gap_inc == GAP_N);
  assign bad_event  = (state == SEEK && !sync_hit && gap_hit) ||
                      (state == COLLECT && frame_last && !crc_ok && locked);

  always_ff @(posedge clk_sys) begin
    data_valid  <= 1'b0;
    frame_error <= 1'b0;
    seq_error   <= 1'b0;
    sync_lost   <= 1'b0;
    if (rst) begin
      state      <= HUNT;
      win        <= '0;
      fill       <= '0;
      bit_cnt    <= '0;
      crc        <= '0;
      shreg      <= '0;
      good_cnt   <= '0;
      err_cnt    <= '0;
      gap_cnt    <= '0;
      prev_valid <= 1'b0;
      prev_cnt   <= '0;
      data_out   <= '0;
      cnt_out    <= '0;
      locked     <= 1'b0;
    end else if (bit_valid) begin
      win <= win_next[6:0];
      if (fill != 3'd7) fill <= fill + 3'd1;
      case (state)
        HUNT: begin
          if (sync_hit) begin
            state   <= COLLECT;
            bit_cnt <= '0;
            crc     <= SYNC_CRC;
          end
        end
        SEEK: begin
          if (sync_hit) begin
            state   <= COLLECT;
            bit_cnt <= '0;
            crc     <= SYNC_CRC;
            gap_cnt <= '0;
          end else if (gap_hit) begin
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_inc;
          end
        end
        COLLECT: begin
          shreg   <= full[COLLECT_BITS-2:0];
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_cnt < BW'(BODY_W)) crc <= crc_step(crc, bit_in);
          if (frame_last) begin
            fill    <= '0;
            gap_cnt <= '0;
            if (crc_ok) begin
              data_valid <= 1'b1;
              data_out   <= rx_data;
              cnt_out    <= rx_cnt;
              seq_error  <= prev_valid && (rx_cnt != prev_cnt + CNT_W'(1));
              prev_valid <= 1'b1;
              prev_cnt   <= rx_cnt;
              err_cnt    <= '0;
              good_cnt   <= good_inc;
              locked     <= locked || (good_inc == LOCK_N);
              state      <= (locked || (good_inc == LOCK_N)) ? SEEK : HUNT;
            end else begin
              frame_error <= 1'b1;
              if (!locked) begin
                state      <= HUNT;
                good_cnt   <= '0;
                prev_valid <= 1'b0;
              end else begin
                state <= SEEK;
              end
            end
          end
        end
        default: state <= HUNT;
      endcase
      // Loss overrides whatever next state the case above picked.
      if (bad_event) begin
        if (err_inc == LOSS_N) begin
          sync_lost  <= 1'b1;
          locked     <= 1'b0;
          state      <= HUNT;
          fill       <= '0;
          good_cnt   <= '0;
          err_cnt    <= '0;
          gap_cnt    <= '0;
          prev_valid <= 1'b0;
        end else begin
          err_cnt <= err_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_rhs2116_frame_deframer.sv
// tb/tb_rhs2116_frame_deframer.sv - table-driven and randomized frame-level checks of rhs2116_frame_deframer
module tb_rhs2116_frame_deframer;

  localparam int GAP  = 64;
  localparam int LOCK = 2;
  localparam int LOSS = 3;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic [31:0] data_out;
  logic [7:0]  cnt_out;
  logic        data_valid, locked, frame_error, seq_error, sync_lost;

  rhs2116_frame_deframer #(
    .SYNC_WORD(8'hAA), .CNT_W(8), .DATA_W(32), .CRC_POLY(8'h07),
    .LOCK_FRAMES(LOCK), .LOSS_ERRORS(LOSS), .MAX_GAP(GAP)
  ) dut (
    .clk_sys(clk_sys), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(data_out), .cnt_out(cnt_out), .data_valid(data_valid),
    .locked(locked), .frame_error(frame_error), .seq_error(seq_error),
    .sync_lost(sync_lost)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit          rst_before;
    logic [7:0]  cnt;
    logic [31:0] data;
    logic [7:0]  flip;
    logic [4:0]  exp;
  } vec_t;

  vec_t tbl[14];

  int checks = 0;
  int errors = 0;
  int duty   = 100;

  int n_dv = 0, n_fe = 0, n_seq = 0, n_lost = 0;
  int e_dv = 0, e_fe = 0, e_seq = 0, e_lost = 0;

  bit          m_locked, m_prev_v;
  int          m_good, m_err;
  logic [7:0]  m_prev, m_last_cnt;
  logic [31:0] m_last_data;

  always @(negedge clk_sys) begin
    if (data_valid)  n_dv++;
    if (frame_error) n_fe++;
    if (seq_error)   n_seq++;
    if (sync_lost)   n_lost++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC by long division of the zero-augmented message by x^8+x^2+x+1.
  function automatic logic [7:0] crc_gold(input logic [47:0] msg);
    logic [55:0] r;
    r = {msg, 8'h00};
    for (int i = 55; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic model_reset();
    m_locked = 0; m_prev_v = 0; m_good = 0; m_err = 0;
    m_prev = 0; m_last_cnt = 0; m_last_data = 0;
  endtask

  task automatic model_lose();
    m_locked = 0; m_good = 0; m_err = 0; m_prev_v = 0;
  endtask

  // Idle bits plus the 7 leading sync bits all count toward the gap; the 8th sync bit is the match.
  task automatic model_gap(input int g);
    for (int k = 0; k < (g + 7) / GAP; k++) begin
      if (m_locked) begin
        m_err++;
        if (m_err == LOSS) begin
          e_lost++;
          model_lose();
        end
      end
    end
  endtask

  task automatic send_bit(input logic b);
    while (int'($urandom_range(99)) >= duty) begin
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
      @(posedge clk_sys); #1;
    end
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk_sys); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_idle(input int g);
    model_gap(g);
    for (int i = 0; i < g; i++) send_bit(1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'($urandom);
      bit_in    = 1'($urandom);
      @(posedge clk_sys); #1;
      chk("reset_outputs", {data_out, cnt_out, data_valid, locked, frame_error, seq_error, sync_lost}, 64'd0);
    end
    rst       = 1'b0;
    bit_valid = 1'b0;
    model_reset();
  endtask

  task automatic send_frame(input logic [7:0] cnt, input logic [31:0] data,
                            input logic [7:0] flip, output logic [4:0] seen);
    logic [55:0] f;
    bit x_dv, x_fe, x_seq, x_lost;
    f = {8'hAA, cnt, data, crc_gold({8'hAA, cnt, data}) ^ flip};
    for (int i = 55; i >= 0; i--) send_bit(f[i]);
    x_dv = 0; x_fe = 0; x_seq = 0; x_lost = 0;
    if (flip == 8'h00) begin
      x_dv  = 1;
      x_seq = m_prev_v && (cnt != m_prev + 8'd1);
      m_prev = cnt; m_prev_v = 1; m_err = 0;
      if (m_good < LOCK) m_good++;
      if (m_good >= LOCK) m_locked = 1;
      m_last_cnt = cnt; m_last_data = data;
    end else begin
      x_fe = 1;
      if (!m_locked) begin
        m_good = 0; m_prev_v = 0;
      end else begin
        m_err++;
        if (m_err == LOSS) begin
          x_lost = 1;
          model_lose();
        end
      end
    end
    e_dv += int'(x_dv); e_fe += int'(x_fe); e_seq += int'(x_seq); e_lost += int'(x_lost);
    chk("data_valid",  data_valid,  x_dv);
    chk("frame_error", frame_error, x_fe);
    chk("seq_error",   seq_error,   x_seq);
    chk("sync_lost",   sync_lost,   x_lost);
    chk("locked",      locked,      m_locked);
    chk("data_out",    data_out,    m_last_data);
    chk("cnt_out",     cnt_out,     m_last_cnt);
    seen = {data_valid, frame_error, seq_error, sync_lost, locked};
  endtask

  task automatic chk_counts();
    bit_valid = 1'b0;
    @(posedge clk_sys); #1;
    chk("count_data_valid",  n_dv,   e_dv);
    chk("count_frame_error", n_fe,   e_fe);
    chk("count_seq_error",   n_seq,  e_seq);
    chk("count_sync_lost",   n_lost, e_lost);
  endtask

  initial begin
    logic [4:0]  seen;
    logic [7:0]  cnt, flip;
    logic [55:0] f;
    int          g, k;

    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0;
    tbl[0]  = '{0, 8'h00, 32'h12345678, 8'h00, 5'b10000};
    tbl[1]  = '{0, 8'h01, 32'h87654321, 8'h00, 5'b10001};
    tbl[2]  = '{1, 8'h02, 32'hDEADBEEF, 8'h01, 5'b01000};
    tbl[3]  = '{0, 8'h03, 32'h87654321, 8'h00, 5'b10000};
    tbl[4]  = '{0, 8'h04, 32'hCAFEF00D, 8'h00, 5'b10001};
    tbl[5]  = '{0, 8'h05, 32'h00000000, 8'h00, 5'b10001};
    tbl[6]  = '{0, 8'h07, 32'hFFFFFFFF, 8'h00, 5'b10101};
    tbl[7]  = '{0, 8'h08, 32'h11111111, 8'h80, 5'b01001};
    tbl[8]  = '{0, 8'h09, 32'h22222222, 8'h10, 5'b01001};
    tbl[9]  = '{0, 8'h0A, 32'h33333333, 8'h01, 5'b01010};
    tbl[10] = '{0, 8'h0B, 32'hA5A5A5A5, 8'h00, 5'b10000};
    tbl[11] = '{0, 8'h0D, 32'h5A5A5A5A, 8'h00, 5'b10101};
    tbl[12] = '{0, 8'hFF, 32'h01234567, 8'h00, 5'b10101};
    tbl[13] = '{0, 8'h00, 32'h89ABCDEF, 8'h00, 5'b10001};
    model_reset();

    do_reset(3);
    chk_counts();

    // Second pass repeats the table with bit_valid gapped at a random duty cycle.
    for (int pass = 0; pass < 2; pass++) begin
      duty = (pass == 0) ? 100 : int'($urandom_range(30, 70));
      do_reset(2);
      for (int i = 0; i < 14; i++) begin
        if (tbl[i].rst_before) do_reset(1);
        send_frame(tbl[i].cnt, tbl[i].data, tbl[i].flip, seen);
        chk($sformatf("table_%0d_pass_%0d", i, pass), seen, tbl[i].exp);
      end
      chk_counts();
    end
    duty = 100;

    do_reset(2);
    send_frame(8'h00, 32'h0000AAAA, 8'h00, seen);
    send_frame(8'h01, 32'h0000BBBB, 8'h00, seen);
    send_idle(56);
    send_frame(8'h02, 32'h0000CCCC, 8'h00, seen);
    send_idle(56);
    send_frame(8'h03, 32'h0000DDDD, 8'h40, seen);
    send_frame(8'h04, 32'h0000EEEE, 8'h02, seen);
    chk("match_on_gap_bit_no_event", locked, 1'b1);
    send_frame(8'h05, 32'h0000FFFF, 8'h00, seen);
    send_idle(64);
    send_frame(8'h06, 32'h00001111, 8'h04, seen);
    send_frame(8'h07, 32'h00002222, 8'h08, seen);
    chk("gap_event_then_loss", seen[1], 1'b1);
    send_frame(8'h08, 32'h00003333, 8'h00, seen);
    send_frame(8'h09, 32'h00004444, 8'h00, seen);
    send_idle(192);
    chk("gap192_sync_lost", sync_lost, 1'b1);
    chk("gap192_unlocked", locked, 1'b0);
    send_frame(8'h0A, 32'h00005555, 8'h00, seen);
    chk_counts();

    do_reset(1);
    for (int it = 0; it < 60; it++) begin
      duty = ($urandom_range(2) == 0) ? int'($urandom_range(30, 70)) : 100;
      g = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(0, 200));
      if (g % GAP >= 57) g -= 8;
      cnt  = ($urandom_range(9) < 7) ? m_prev + 8'd1 : 8'($urandom);
      flip = ($urandom_range(4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if ($urandom_range(19) == 0) begin
        f = {8'hAA, cnt, 32'($urandom), 8'($urandom)};
        k = int'($urandom_range(1, 55));
        for (int i = 55; i > 55 - k; i--) send_bit(f[i]);
        do_reset(1);
      end else begin
        send_idle(g);
        send_frame(cnt, 32'($urandom), flip, seen);
      end
    end
    chk_counts();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
